sti_rx: RTL and testbench

- Serial receiver for the STI serial stream: the inverse of the serial transmitter.
- Samples the `so_valid`/`so_data` bit stream and rebuilds the 8/16/24/32-bit frame and its 16-bit payload.
- Honours the same length, bit-order, fill and low-byte configuration the transmitter used.
- Sits at the sink side of the STI link and feeds the DAC/loopback checker with parallel words.

---
 rtl/sti_rx.sv | 163 ++++++++++++++++
 tb/tb_sti_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sti_rx.sv
// STI serial receiver: rebuilds 8/16/24/32-bit frames from a bit stream
// and extracts the 16-bit payload using the transmitter's configuration.
module sti_rx #(
    parameter int PAYLOAD_W = 16,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 si_valid,
    input  logic                 si_data,
    input  logic                 si_end,
    input  logic                 cfg_msb,
    input  logic [1:0]           cfg_length,
    input  logic                 cfg_fill,
    input  logic                 cfg_low,
    output logic                 po_valid,
    output logic [31:0]          po_word,
    output logic [PAYLOAD_W-1:0] po_data,
    output logic                 po_pad_err,
    output logic                 po_abort,
    output logic [CNT_W-1:0]     po_count,
    output logic                 po_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RECV,
        S_END
    } state_t;

    state_t               state, state_n;
    logic [4:0]           idx, idx_n;
    logic [31:0]          shreg, shreg_n;
    logic                 msb_q, msb_n;
    logic [1:0]           len_q, len_n;
    logic                 fill_q, fill_n;
    logic                 low_q, low_n;

    logic                 valid_n, abort_n, pad_n;
    logic [31:0]          word_n;
    logic [PAYLOAD_W-1:0] data_n;
    logic [CNT_W-1:0]     count_n;

    logic [4:0]           last;
    logic [4:0]           pos;
    logic [4:0]           pos0;
    logic [31:0]          w;
    logic [PAYLOAD_W-1:0] ext_data;
    logic                 ext_pad;

    // Index of the final bit is N-1 = 8*len + 7.
    assign last = {len_q, 3'b111};
    assign pos  = msb_q ? (last - idx) : idx;
    assign pos0 = cfg_msb ? {cfg_length, 3'b111} : 5'd0;

    always_comb begin
        w      = shreg;
        w[pos] = si_data;
    end

    always_comb begin
        ext_data = w[15:0];
        ext_pad  = 1'b0;
        unique case (len_q)
            2'd0: ext_data = low_q ? {w[7:0], 8'h00} : {8'h00, w[7:0]};
            2'd1: ext_data = w[15:0];
            2'd2: begin
                ext_data = fill_q ? w[23:8] : w[15:0];
                ext_pad  = fill_q ? |w[7:0] : |w[23:16];
            end
            2'd3: begin
                ext_data = fill_q ? w[31:16] : w[15:0];
                ext_pad  = fill_q ? |w[15:0] : |w[31:16];
            end
        endcase
    end

    always_comb begin
        state_n = state;
        idx_n   = idx;
        shreg_n = shreg;
        msb_n   = msb_q;
        len_n   = len_q;
        fill_n  = fill_q;
        low_n   = low_q;
        valid_n = 1'b0;
        abort_n = 1'b0;
        word_n  = po_word;
        data_n  = po_data;
        pad_n   = po_pad_err;
        count_n = po_count;
        unique case (state)
            S_IDLE: begin
                if (si_end) begin
                    state_n = S_END;
                end else if (si_valid) begin
                    msb_n   = cfg_msb;
                    len_n   = cfg_length;
                    fill_n  = cfg_fill;
                    low_n   = cfg_low;
                    shreg_n = 32'({si_data}) << pos0;
                    idx_n   = 5'd1;
                    state_n = S_RECV;
                end
            end
            S_RECV: begin
                if (!si_valid) begin
                    abort_n = 1'b1;
                    idx_n   = 5'd0;
                    state_n = S_IDLE;
                end else if (idx == last) begin
                    valid_n = 1'b1;
                    word_n  = w;
                    data_n  = ext_data;
                    pad_n   = ext_pad;
                    count_n = po_count + CNT_W'(1);
                    idx_n   = 5'd0;
                    state_n = S_IDLE;
                end else begin
                    shreg_n = w;
                    idx_n   = idx + 5'd1;
                end
            end
            S_END: ;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            idx        <= '0;
            shreg      <= '0;
            msb_q      <= 1'b0;
            len_q      <= '0;
            fill_q     <= 1'b0;
            low_q      <= 1'b0;
            po_valid   <= 1'b0;
            po_abort   <= 1'b0;
            po_word    <= '0;
            po_data    <= '0;
            po_pad_err <= 1'b0;
            po_count   <= '0;
            po_done    <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            shreg      <= shreg_n;
            msb_q      <= msb_n;
            len_q      <= len_n;
            fill_q     <= fill_n;
            low_q      <= low_n;
            po_valid   <= valid_n;
            po_abort   <= abort_n;
            po_word    <= word_n;
            po_data    <= data_n;
            po_pad_err <= pad_n;
            po_count   <= count_n;
            po_done    <= (state_n == S_END);
        end
    end

endmodule

// File: tb/tb_sti_rx.sv
// Randomized bench for sti_rx against a frame-level reference model.
module tb_sti_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        si_valid = 1'b0;
    logic        si_data = 1'b0;
    logic        si_end = 1'b0;
    logic        cfg_msb = 1'b0;
    logic [1:0]  cfg_length = 2'd0;
    logic        cfg_fill = 1'b0;
    logic        cfg_low = 1'b0;
    logic        po_valid;
    logic [31:0] po_word;
    logic [15:0] po_data;
    logic        po_pad_err;
    logic        po_abort;
    logic [15:0] po_count;
    logic        po_done;

    int total = 0;
    int bad = 0;

    sti_rx #(.PAYLOAD_W(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .si_valid(si_valid), .si_data(si_data), .si_end(si_end),
        .cfg_msb(cfg_msb), .cfg_length(cfg_length),
        .cfg_fill(cfg_fill), .cfg_low(cfg_low),
        .po_valid(po_valid), .po_word(po_word), .po_data(po_data),
        .po_pad_err(po_pad_err), .po_abort(po_abort),
        .po_count(po_count), .po_done(po_done)
    );

    always #5 clk = ~clk;

    // Reference model: receiver mode plus bits collected so far.
    int        m_mode = 0;
    int        m_n = 8;
    bit        m_msb, m_fill, m_low;
    bit        bits[$];
    bit        e_valid, e_abort, e_pad, e_done;
    bit [31:0] e_word;
    bit [15:0] e_data, e_count;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        bits.delete();
        e_valid = 0; e_abort = 0; e_pad = 0; e_done = 0;
        e_word = 0; e_data = 0; e_count = 0;
    endtask

    task automatic finish_frame();
        bit [31:0] wd;
        bit [31:0] pad;
        wd = 0;
        for (int i = 0; i < m_n; i++)
            if (bits[i]) wd = wd | (32'd1 << (m_msb ? m_n - 1 - i : i));
        pad = 0;
        case (m_n)
            8:  e_data = m_low ? 16'(wd * 256) : 16'(wd);
            16: e_data = 16'(wd);
            24: begin
                e_data = m_fill ? 16'(wd / 256) : 16'(wd % 65536);
                pad = m_fill ? wd % 256 : wd / 65536;
            end
            default: begin
                e_data = m_fill ? 16'(wd / 65536) : 16'(wd % 65536);
                pad = m_fill ? wd % 65536 : wd / 65536;
            end
        endcase
        e_word = wd;
        e_pad = (pad != 0);
        e_valid = 1;
        e_count = e_count + 16'd1;
    endtask

    task automatic model_step(input bit v, input bit d, input bit en);
        e_valid = 0;
        e_abort = 0;
        if (m_mode == 0) begin
            if (en) begin
                m_mode = 2;
                e_done = 1;
            end else if (v) begin
                m_n = 8 * (int'(cfg_length) + 1);
                m_msb = cfg_msb; m_fill = cfg_fill; m_low = cfg_low;
                bits.delete();
                bits.push_back(d);
                m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (v) begin
                bits.push_back(d);
                if (bits.size() == m_n) begin
                    finish_frame();
                    m_mode = 0;
                end
            end else begin
                e_abort = 1;
                m_mode = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("valid", po_valid, e_valid);
        chk("abort", po_abort, e_abort);
        chk("word", po_word, e_word);
        chk("data", po_data, e_data);
        chk("pad", po_pad_err, e_pad);
        chk("count", po_count, e_count);
        chk("done", po_done, e_done);
    endtask

    task automatic cyc(input bit v, input bit d, input bit en);
        si_valid = v;
        si_data = d;
        si_end = en;
        model_step(v, d, en);
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rst = 1;
        si_valid = 0;
        si_end = 0;
        @(posedge clk);
        #1;
        rst = 0;
        model_reset();
        compare_all();
    endtask

    // Sends nb bits of word value; optionally scrambles cfg after bit 0.
    task automatic send_bits(input bit [1:0] len, input bit msb,
                             input bit fill, input bit low,
                             input bit [31:0] value, input int nb,
                             input bit scramble);
        int n;
        n = 8 * (int'(len) + 1);
        cfg_length = len; cfg_msb = msb; cfg_fill = fill; cfg_low = low;
        for (int i = 0; i < nb; i++) begin
            cyc(1'b1, value[msb ? n - 1 - i : i], 1'b0);
            if (scramble) begin
                cfg_length = 2'($urandom);
                cfg_msb = 1'($urandom);
                cfg_fill = 1'($urandom);
                cfg_low = 1'($urandom);
            end
        end
    endtask

    initial begin
        model_reset();
        #1;
        do_reset();
        chk("rst_valid", po_valid, 0);

        send_bits(2'd1, 1, 0, 0, 32'h0000A5C3, 16, 0);
        chk("a5c3_data", po_data, 32'hA5C3);
        chk("a5c3_word", po_word, 32'h0000A5C3);
        chk("a5c3_count", po_count, 1);
        cyc(0, 0, 0);

        send_bits(2'd0, 0, 0, 1, 32'h3C, 8, 0);
        chk("b8_data", po_data, 32'h3C00);
        chk("b8_word", po_word, 32'h3C);
        cyc(0, 0, 0);

        send_bits(2'd2, 1, 1, 0, 32'h00123400, 24, 0);
        chk("b24_data", po_data, 32'h1234);
        chk("b24_pad", po_pad_err, 0);
        send_bits(2'd2, 1, 1, 0, 32'h00123401, 24, 0);
        chk("b24_pad1", po_pad_err, 1);
        cyc(0, 0, 0);

        do_reset();
        send_bits(2'd3, 0, 0, 0, 32'h0000BEEF, 32, 1);
        chk("beef1", po_data, 32'hBEEF);
        send_bits(2'd3, 0, 0, 0, 32'h0000BEEF, 32, 0);
        chk("beef2", po_data, 32'hBEEF);
        chk("beef_count", po_count, 2);
        cyc(0, 0, 0);

        send_bits(2'd1, 1, 0, 0, 32'h00001234, 5, 0);
        cyc(0, 0, 0);
        chk("abort_pulse", po_abort, 1);
        chk("abort_count", po_count, 2);
        send_bits(2'd1, 0, 0, 0, 32'h00005A5A, 16, 0);
        chk("after_abort", po_data, 32'h5A5A);
        cyc(0, 0, 0);

        for (int k = 0; k < 300; k++) begin
            bit [1:0] len;
            int n, nb, gap;
            bit ab;
            len = 2'($urandom);
            n = 8 * (int'(len) + 1);
            ab = ($urandom_range(0, 5) == 0);
            nb = ab ? int'($urandom_range(1, n - 1)) : n;
            gap = ab ? int'($urandom_range(1, 2)) : int'($urandom_range(0, 2));
            send_bits(len, 1'($urandom), 1'($urandom), 1'($urandom),
                      $urandom, nb, 1'($urandom));
            for (int g = 0; g < gap; g++) cyc(0, 1'($urandom), 0);
        end

        cyc(1, 1, 1);
        chk("end_done", po_done, 1);
        send_bits(2'd0, 1, 0, 0, 32'hFF, 8, 0);
        cyc(0, 0, 1);
        chk("end_novalid", po_valid, 0);

        do_reset();
        send_bits(2'd1, 1, 0, 0, 32'h0000FFFF, 6, 0);
        do_reset();
        chk("rst_done", po_done, 0);
        chk("rst_count", po_count, 0);
        send_bits(2'd1, 1, 0, 0, 32'h0000C001, 16, 0);
        chk("post_rst", po_data, 32'hC001);
        cyc(0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
